caja_musical: RTL and testbench

CAJA_MUSICAL -- requirements
Module: caja_musical

---
 rtl/caja_musical_pkg.sv | 48 ++++
 rtl/caja_tone_gen.sv | 28 ++
 rtl/caja_musical.sv | 54 +++++
 tb/tb_caja_musical.sv | 90 +++++++++
 4 files changed

// File: rtl/caja_musical_pkg.sv
// Note codes, tone half-period table and the 32-slot song ROM for the music box.
package caja_musical_pkg;
  localparam int CODE_W = 4;
  localparam int IDX_W  = 5;
  localparam int TONE_W = 15;

  localparam logic [CODE_W-1:0] N_REST = 4'd0;
  localparam logic [CODE_W-1:0] N_C4   = 4'd1;
  localparam logic [CODE_W-1:0] N_D4   = 4'd3;
  localparam logic [CODE_W-1:0] N_E4   = 4'd5;
  localparam logic [CODE_W-1:0] N_F4   = 4'd6;
  localparam logic [CODE_W-1:0] N_G4   = 4'd8;
  localparam logic [CODE_W-1:0] N_A4   = 4'd10;

  // Half period in 12 MHz cycles, round(6e6/f); rest gets a harmless nonzero value.
  function automatic logic [TONE_W-1:0] hp_of(input logic [CODE_W-1:0] code);
    case (code)
      4'd1:    hp_of = 15'd22933;
      4'd2:    hp_of = 15'd21646;
      4'd3:    hp_of = 15'd20431;
      4'd4:    hp_of = 15'd19285;
      4'd5:    hp_of = 15'd18202;
      4'd6:    hp_of = 15'd17181;
      4'd7:    hp_of = 15'd16216;
      4'd8:    hp_of = 15'd15306;
      4'd9:    hp_of = 15'd14447;
      4'd10:   hp_of = 15'd13636;
      4'd11:   hp_of = 15'd12871;
      4'd12:   hp_of = 15'd12149;
      4'd13:   hp_of = 15'd11467;
      4'd14:   hp_of = 15'd10216;
      4'd15:   hp_of = 15'd9101;
      default: hp_of = 15'd1;
    endcase
  endfunction

  function automatic logic [CODE_W-1:0] song_code(input logic [IDX_W-1:0] i);
    case (i)
      5'd0, 5'd1, 5'd14:                           song_code = N_C4;
      5'd2, 5'd3, 5'd6, 5'd16, 5'd17, 5'd24, 5'd25: song_code = N_G4;
      5'd4, 5'd5:                                  song_code = N_A4;
      5'd8, 5'd9, 5'd18, 5'd19, 5'd26, 5'd27:      song_code = N_F4;
      5'd10, 5'd11, 5'd20, 5'd21, 5'd28, 5'd29:    song_code = N_E4;
      5'd12, 5'd13, 5'd22, 5'd30:                  song_code = N_D4;
      default:                                     song_code = N_REST;
    endcase
  endfunction
endpackage

// File: rtl/caja_tone_gen.sv
// Square-wave generator; enable means "the coming cycle sounds", so the
// registered tone is already low on the first silent cycle.
module caja_tone_gen
  import caja_musical_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [TONE_W-1:0] half_period,
  output logic              tone
);
  logic [TONE_W-1:0] cnt;
  logic              on;

  // 'on' marks the current cycle as sounding; a silent->sounding step restarts at phase 0.
  always_ff @(posedge clk) begin
    if (rst || !enable || !on) begin
      cnt  <= '0;
      tone <= 1'b0;
      on   <= enable;
    end else if (cnt == half_period - TONE_W'(1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt  <= cnt + TONE_W'(1);
    end
  end
endmodule

// File: rtl/caja_musical.sv
// Free-running music box: steps through the song ROM one slot at a time and
// drives a phase-aligned square wave with a short silence closing every slot.
module caja_musical
  import caja_musical_pkg::*;
#(
  parameter int NOTE_TICKS = 3_000_000,
  parameter int GAP_TICKS  = 120_000
) (
  input  logic clk,
  input  logic rst,
  output logic speaker
);
  localparam int              SW        = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [SW-1:0]   LAST      = SW'(NOTE_TICKS - 1);
  localparam logic [31:0]     SOUND_END = 32'(NOTE_TICKS - GAP_TICKS);

  logic [SW-1:0]     slot_cnt, slot_nxt;
  logic [IDX_W-1:0]  note_idx, idx_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              en_nxt;

  // Next-cycle state drives the tone generator so its registered output is never a cycle late.
  always_comb begin
    slot_nxt = slot_cnt + SW'(1);
    idx_nxt  = note_idx;
    if (rst) begin
      slot_nxt = '0;
      idx_nxt  = '0;
    end else if (slot_cnt == LAST) begin
      slot_nxt = '0;
      idx_nxt  = note_idx + IDX_W'(1);
    end
    code_nxt = song_code(idx_nxt);
    en_nxt   = (code_nxt != N_REST) && (32'(slot_nxt) < SOUND_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      note_idx <= '0;
    end else begin
      slot_cnt <= slot_nxt;
      note_idx <= idx_nxt;
    end
  end

  caja_tone_gen u_tone (
    .clk        (clk),
    .rst        (rst),
    .enable     (en_nxt),
    .half_period(hp_of(code_nxt)),
    .tone       (speaker)
  );
endmodule

// File: tb/tb_caja_musical.sv
// Directed checks on four instances with shortened slots so the run stays short.
module tb_caja_musical;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c, rst_d;
  logic spk_a, spk_b, spk_c, spk_d;
  int   ncmp = 0;
  int   nerr = 0;
  int   cyc  = 0;

  always #5 clk = ~clk;

  // a: full C4 period; b: short slots for index/rest/wrap; c: mid-note reset; d: gap cuts a high phase
  caja_musical #(.NOTE_TICKS(47000), .GAP_TICKS(1000))  dut_a (.clk(clk), .rst(rst_a), .speaker(spk_a));
  caja_musical #(.NOTE_TICKS(1000),  .GAP_TICKS(100))   dut_b (.clk(clk), .rst(rst_b), .speaker(spk_b));
  caja_musical #(.NOTE_TICKS(47000), .GAP_TICKS(1000))  dut_c (.clk(clk), .rst(rst_c), .speaker(spk_c));
  caja_musical #(.NOTE_TICKS(40000), .GAP_TICKS(5000))  dut_d (.clk(clk), .rst(rst_d), .speaker(spk_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Cycle k = the clock period in which the slot counter holds k; sampled at the falling edge.
  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_spk", {29'd0, spk_a, spk_c, spk_d}, 32'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    cyc = 0;
    chk("c0_spk_a", spk_a, 0);
    chk("c0_idx_b", dut_b.note_idx, 0);

    wait_to(6500);  chk("b_slot6_en",  dut_b.en_nxt, 1);
    wait_to(6950);  chk("b_slot6_gap", dut_b.en_nxt, 0);
    wait_to(7500);  chk("b_rest_en",   dut_b.en_nxt, 0);
                    chk("b_idx7",      dut_b.note_idx, 7);
                    chk("b_rest_spk",  spk_b, 0);

    wait_to(22932); chk("a_pre_rise", spk_a, 0);
                    chk("d_pre_rise", spk_d, 0);
    wait_to(22933); chk("a_rise",     spk_a, 1);
                    chk("d_rise",     spk_d, 1);

    wait_to(30000); chk("c_high", spk_c, 1);
    rst_c = 1'b1;
    wait_to(30001); chk("c_rst_low", spk_c, 0);
    wait_to(30004); chk("c_rst_hold", spk_c, 0);
    rst_c = 1'b0;   // c restarts: its cycle 0 is 30004

    wait_to(31999); chk("b_idx31",  dut_b.note_idx, 31);
    wait_to(32000); chk("b_wrap",   dut_b.note_idx, 0);
                    chk("b_slot0",  dut_b.slot_cnt, 0);

    wait_to(34999); chk("d_last_sound", spk_d, 1);
    wait_to(35000); chk("d_gap_start",  spk_d, 0);
    wait_to(39999); chk("d_gap_end",    spk_d, 0);
    wait_to(40000); chk("d_slot1_low",  spk_d, 0);

    wait_to(42500); chk("b_idx10", dut_b.note_idx, 10);
    rst_b = 1'b1;
    wait_to(42501); chk("b_rst_idx",  dut_b.note_idx, 0);
                    chk("b_rst_slot", dut_b.slot_cnt, 0);
    rst_b = 1'b0;

    wait_to(45865); chk("a_pre_fall", spk_a, 1);
    wait_to(45866); chk("a_fall",     spk_a, 0);
    wait_to(46500); chk("a_gap",      spk_a, 0);

    wait_to(52936); chk("c_pre_rise", spk_c, 0);
    wait_to(52937); chk("c_rise",     spk_c, 1);

    wait_to(62932); chk("d_slot1_pre_rise", spk_d, 0);
    wait_to(62933); chk("d_slot1_rise",     spk_d, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
